// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary neural-network datapath.
// Used by the neuron accumulator and the next-layer blocks.
package tnn_pkg;

  localparam int PC22_W = 5;

  typedef enum logic [1:0] {
    TRIT_ZERO = 2'b00,
    TRIT_POS  = 2'b01,
    TRIT_NEG  = 2'b11
  } trit_t;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int w);
    int hi;
    int lo;
    int s;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = a + b;
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/tnn_neuron_accum_if.sv
// Chunk-in / trit-out bundle of one ternary neuron accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface tnn_neuron_accum_if
  import tnn_pkg::*;
#(
  parameter int PC_W  = PC22_W,
  parameter int ACC_W = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PC_W-1:0]         in_pos;
  logic [PC_W-1:0]         in_neg;
  logic                    in_last;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  trit_t                   out_trit;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_err;

  modport slave (
    input  in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, out_trit, out_sum, out_err
  );

  modport master (
    output in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, out_trit, out_sum, out_err
  );

endinterface

// File: rtl/tnn_trit_cmp.sv
// Threshold compare of a signed sum into a trit; the +1 rule wins when the
// thresholds overlap.
module tnn_trit_cmp
  import tnn_pkg::*;
#(
  parameter int ACC_W = 9
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic signed [ACC_W-1:0] thr_hi_i,
  input  logic signed [ACC_W-1:0] thr_lo_i,
  output trit_t                   trit_o
);

  always_comb begin
    trit_o = TRIT_ZERO;
    if (sum_i >= thr_hi_i) begin
      trit_o = TRIT_POS;
    end else if (sum_i <= thr_lo_i) begin
      trit_o = TRIT_NEG;
    end
  end

endmodule

// File: rtl/tnn_neuron_accum.sv
// Accumulates (pos - neg) popcounts over the chunks of one ternary neuron, saturating,
// and emits one registered trit/sum/err result per neuron through a valid/ready stage.
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int PC_W      = PC22_W,
  parameter int ACC_W     = 9,
  parameter int MAX_BEATS = 8
) (
  input  logic                clk,
  input  logic                rst,
  tnn_neuron_accum_if.slave   bus
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BW-1:0]           beats_q, beats_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  trit_t                   out_trit_q, out_trit_d;
  logic                    out_err_q, out_err_d;

  logic [PC_W-1:0]         pos_w;
  logic [PC_W-1:0]         neg_w;
  logic signed [ACC_W-1:0] nxt;
  int                      raw_sum;
  int                      sat_sum;
  logic                    clamp_now;
  logic                    in_ready;
  logic                    accept;
  logic                    beat_limit;
  logic                    final_beat;
  logic                    overrun;
  trit_t                   trit_nxt;

  assign pos_w    = bus.in_pos;
  assign neg_w    = bus.in_neg;
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    raw_sum    = int'(acc_q) + int'(pos_w) - int'(neg_w);
    sat_sum    = sat_add(int'(acc_q), int'(pos_w) - int'(neg_w), ACC_W);
    clamp_now  = (sat_sum != raw_sum);
    nxt        = ACC_W'(sat_sum);
    beat_limit = (int'(beats_q) + 1 == MAX_BEATS);
    final_beat = accept && (bus.in_last || beat_limit);
    overrun    = final_beat && !bus.in_last;
  end

  tnn_trit_cmp #(.ACC_W(ACC_W)) u_cmp (
    .sum_i    (nxt),
    .thr_hi_i (bus.thr_hi),
    .thr_lo_i (bus.thr_lo),
    .trit_o   (trit_nxt)
  );

  always_comb begin
    acc_d       = acc_q;
    beats_d     = beats_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_trit_d  = out_trit_q;
    out_err_d   = out_err_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // A final beat may land on the same edge the previous result retires.
    if (accept) begin
      if (final_beat) begin
        acc_d       = '0;
        beats_d     = '0;
        sat_d       = 1'b0;
        out_valid_d = 1'b1;
        out_sum_d   = nxt;
        out_trit_d  = trit_nxt;
        out_err_d   = sat_q || clamp_now || overrun;
      end else begin
        acc_d   = nxt;
        beats_d = beats_q + 1'b1;
        sat_d   = sat_q || clamp_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      beats_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_trit_q  <= TRIT_ZERO;
      out_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_trit_q  <= out_trit_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_trit  = out_trit_q;
  assign bus.out_err   = out_err_q;

endmodule
